// File: rtl/uart_cmd_bridge_if.sv
// uart_cmd_bridge_if
//   Bundles the command-source handshake and the UART byte/feedback signals
//   that pass through uart_cmd_bridge.
//   master : mode controllers + UART side (drives src_*, tx_ready, rx_*)
//   slave  : the bridge itself (drives src_ready, tx_bits, fb_*)
// Signals
//   src_sel    SEL_W            index of the source allowed to enqueue
//   src_bits   NUM_SRC*DATA_W   source i byte at [i*DATA_W +: DATA_W]
//   src_valid  NUM_SRC          source i has a byte
//   src_ready  NUM_SRC          byte of source i accepted when valid&ready
//   tx_bits    DATA_W           byte presented to the UART transmitter
//   tx_ready   1                UART consumed tx_bits (1-cycle pulse)
//   rx_bits    DATA_W           byte received by the UART
//   rx_valid   1                rx_bits valid (1-cycle pulse)
//   fb_bits    DATA_W           last received byte, registered
//   fb_valid   1                fb_bits just updated (1-cycle pulse)
interface uart_cmd_bridge_if #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 1
);
  logic [SEL_W-1:0]          src_sel;
  logic [NUM_SRC*DATA_W-1:0] src_bits;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [DATA_W-1:0]         tx_bits;
  logic                      tx_ready;
  logic [DATA_W-1:0]         rx_bits;
  logic                      rx_valid;
  logic [DATA_W-1:0]         fb_bits;
  logic                      fb_valid;

  modport master (
    output src_sel, src_bits, src_valid, tx_ready, rx_bits, rx_valid,
    input  src_ready, tx_bits, fb_bits, fb_valid
  );

  modport slave (
    input  src_sel, src_bits, src_valid, tx_ready, rx_bits, rx_valid,
    output src_ready, tx_bits, fb_bits, fb_valid
  );
endinterface

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge
//   N-source command bridge between the mode controllers and the UART.
//   The selected source pushes bytes into a TX FIFO that the UART drains
//   with tx_ready pulses; the head is shown on a registered tx_bits
//   (IDLE_BYTE while empty). Received UART bytes are registered onto
//   fb_bits with a one-cycle fb_valid pulse. Single clock domain (UART clock).
// Ports
//   clk         UART clock, the only clock
//   rst_n       asynchronous reset, active-low
//   bus         uart_cmd_bridge_if.slave (source handshake, tx/rx, feedback)
//   flush       synchronous clear of the FIFO and the overflow flag
//   fifo_count  FIFO occupancy 0..FIFO_DEPTH
//   overflow    sticky: selected source was stalled by a full FIFO
// Configuration
//   UART_CMD_BRIDGE_FLUSH_ON_SWITCH_EN : when defined, a change of src_sel
//   (against its registered copy) acts as a one-cycle internal flush so
//   commands queued by the previous mode are discarded.
module uart_cmd_bridge #(
  parameter int                NUM_SRC    = 2,
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 8,
  parameter int                SEL_W      = 1,
  parameter logic [DATA_W-1:0] IDLE_BYTE  = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_cmd_bridge_if.slave            bus,
  input  logic                        flush,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_nxt;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic [DATA_W-1:0]  tx_q;
  logic [DATA_W-1:0]  tx_nxt;
  logic [DATA_W-1:0]  fb_bits_q;
  logic               fb_valid_q;
  logic               overflow_q;

  logic [NUM_SRC-1:0] sel_onehot;
  logic               sel_valid;
  logic [DATA_W-1:0]  sel_data;
  logic               full;
  logic               empty;
  logic               switch_flush;
  logic               clear;
  logic               push;
  logic               pop;
  logic               stall;

  // Source decode; src_sel values with no matching source select nothing.
  always_comb begin
    sel_onehot = '0;
    sel_valid  = 1'b0;
    sel_data   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.src_sel == SEL_W'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_valid     = bus.src_valid[i];
        sel_data      = bus.src_bits[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef UART_CMD_BRIDGE_FLUSH_ON_SWITCH_EN
  logic [SEL_W-1:0] sel_q;

  // Remembers last cycle's selection so a mode switch can be detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= bus.src_sel;
    end
  end

  assign switch_flush = (bus.src_sel != sel_q);
`else
  assign switch_flush = 1'b0;
`endif

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign clear = flush | switch_flush;

  // Ready never looks at tx_ready: a full FIFO refuses even while popping.
  // It is also held low while reset is asserted.
  assign bus.src_ready = (rst_n && !full && !clear) ? sel_onehot : '0;

  assign push  = sel_valid && !full && !clear;
  assign pop   = bus.tx_ready && !empty && !clear;
  assign stall = sel_valid && full && !clear;

  // Next occupancy, read pointer and the byte to show on tx_bits.
  always_comb begin
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr + PTR_W'(pop);
    tx_nxt     = IDLE_BYTE;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
    if (clear || count_nxt == '0) begin
      tx_nxt = IDLE_BYTE;
    end else if (count == CNT_W'(pop)) begin
      // Everything stored is gone after this pop, so the byte being pushed
      // now is the new head; it is not in the memory yet.
      tx_nxt = sel_data;
    end else begin
      tx_nxt = mem[rd_ptr_nxt];
    end
  end

  // FIFO pointers, occupancy and the registered head byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      tx_q   <= IDLE_BYTE;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      tx_q   <= IDLE_BYTE;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      tx_q   <= tx_nxt;
    end
  end

  // Storage needs no reset; occupancy decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sel_data;
    end
  end

  // Sticky overflow, cleared only by a flush (external or on switch).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (clear) begin
      overflow_q <= 1'b0;
    end else if (stall) begin
      overflow_q <= 1'b1;
    end
  end

  // Feedback path is deliberately unaffected by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_bits_q  <= '0;
      fb_valid_q <= 1'b0;
    end else begin
      fb_valid_q <= bus.rx_valid;
      if (bus.rx_valid) begin
        fb_bits_q <= bus.rx_bits;
      end
    end
  end

  assign bus.tx_bits  = tx_q;
  assign bus.fb_bits  = fb_bits_q;
  assign bus.fb_valid = fb_valid_q;
  assign fifo_count   = count;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb_uart_cmd_bridge
//   Self-checking bench for uart_cmd_bridge (NUM_SRC=2, DATA_W=8,
//   FIFO_DEPTH=8). A vector table, hand-written corner sequences and a
//   randomized run against a queue-based reference model.
module tb_uart_cmd_bridge;
  localparam int NUM_SRC    = 2;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int SEL_W      = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [3:0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  uart_cmd_bridge_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

  uart_cmd_bridge #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
    .SEL_W(SEL_W), .IDLE_BYTE(8'h00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .flush(flush),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       f;
    logic       sel;
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       txr;
    logic       rxv;
    logic [7:0] rxb;
    logic [1:0] e_rdy;
    logic [3:0] e_cnt;
    logic [7:0] e_tx;
    logic       e_ovf;
    logic       e_fbv;
    logic [7:0] e_fb;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic f, input logic sel, input logic [1:0] v,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic txr, input logic rxv, input logic [7:0] rxb,
                              input logic [1:0] e_rdy, input logic [3:0] e_cnt,
                              input logic [7:0] e_tx, input logic e_ovf,
                              input logic e_fbv, input logic [7:0] e_fb);
    vec_t r;
    r.f = f; r.sel = sel; r.v = v; r.d0 = d0; r.d1 = d1;
    r.txr = txr; r.rxv = rxv; r.rxb = rxb;
    r.e_rdy = e_rdy; r.e_cnt = e_cnt; r.e_tx = e_tx;
    r.e_ovf = e_ovf; r.e_fbv = e_fbv; r.e_fb = e_fb;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic f, input logic sel, input logic [1:0] v,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic txr, input logic rxv, input logic [7:0] rxb);
    flush         = f;
    bus.src_sel   = sel;
    bus.src_valid = v;
    bus.src_bits  = {d1, d0};
    bus.tx_ready  = txr;
    bus.rx_valid  = rxv;
    bus.rx_bits   = rxb;
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model state
  logic [7:0] mq[$];
  logic       movf;
  logic [7:0] mfb;
  logic       mfbv;
  logic       mprev;

  initial begin
    logic       r_sel;
    logic [1:0] r_v;
    logic [7:0] r_d0;
    logic [7:0] r_d1;
    logic       r_txr;
    logic       r_f;
    logic       r_rxv;
    logic [7:0] r_rxb;
    logic       sw;
    logic       clr;
    logic       mfull;
    logic [1:0] exp_rdy;
    logic [7:0] seq2[3];
    logic [7:0] exp_tx2[3];

    // ---------------- reset values ----------------
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 2'b01, 8'hEE, 8'h00, 1'b0, 1'b0, 8'h00);
    #2;
    check_output("reset_ready", 32'(bus.src_ready), 32'h0);
    do_reset();
    check_output("reset_tx", 32'(bus.tx_bits), 32'h00);
    check_output("reset_count", 32'(fifo_count), 32'd0);
    check_output("reset_ovf", 32'(overflow), 32'd0);
    check_output("reset_fbv", 32'(bus.fb_valid), 32'd0);
    check_output("reset_fb", 32'(bus.fb_bits), 32'h00);

    // ---------------- vector table ----------------
    vecs[0] = mk(0, 0, 2'b01, 8'hA1, 8'h00, 0, 0, 8'h00, 2'b01, 1, 8'hA1, 0, 0, 8'h00);
    vecs[1] = mk(0, 0, 2'b11, 8'hA2, 8'hB9, 0, 0, 8'h00, 2'b01, 2, 8'hA1, 0, 0, 8'h00);
    vecs[2] = mk(0, 0, 2'b01, 8'hA3, 8'hB9, 1, 0, 8'h00, 2'b01, 2, 8'hA2, 0, 0, 8'h00);
    vecs[3] = mk(0, 0, 2'b00, 8'h00, 8'h00, 1, 1, 8'h5A, 2'b01, 1, 8'hA3, 0, 1, 8'h5A);
    vecs[4] = mk(1, 1, 2'b11, 8'hA4, 8'hB1, 1, 0, 8'h00, 2'b00, 0, 8'h00, 0, 0, 8'h5A);
    vecs[5] = mk(0, 1, 2'b00, 8'h00, 8'h00, 1, 1, 8'hC3, 2'b10, 0, 8'h00, 0, 1, 8'hC3);
    vecs[6] = mk(0, 1, 2'b01, 8'h77, 8'h00, 0, 0, 8'h00, 2'b10, 0, 8'h00, 0, 0, 8'hC3);
    vecs[7] = mk(0, 1, 2'b10, 8'h00, 8'hB2, 1, 0, 8'h00, 2'b10, 1, 8'hB2, 0, 0, 8'hC3);
    vecs[8] = mk(0, 1, 2'b00, 8'h00, 8'h00, 0, 0, 8'h00, 2'b10, 1, 8'hB2, 0, 0, 8'hC3);
    vecs[9] = mk(0, 1, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 2'b10, 0, 8'h00, 0, 0, 8'hC3);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].f, vecs[i].sel, vecs[i].v, vecs[i].d0, vecs[i].d1,
                     vecs[i].txr, vecs[i].rxv, vecs[i].rxb);
      #1;
      check_output($sformatf("vec%0d_ready", i), 32'(bus.src_ready), 32'(vecs[i].e_rdy));
      step();
      check_output($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
      check_output($sformatf("vec%0d_tx", i), 32'(bus.tx_bits), 32'(vecs[i].e_tx));
      check_output($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
      check_output($sformatf("vec%0d_fbv", i), 32'(bus.fb_valid), 32'(vecs[i].e_fbv));
      check_output($sformatf("vec%0d_fb", i), 32'(bus.fb_bits), 32'(vecs[i].e_fb));
    end

    // ---------------- reset mid-traffic ----------------
    apply_stimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h00);
    step();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 2'b01, 8'(8'h61 + i), 8'h00, 0, (i == 2), 8'h99);
      step();
    end
    apply_stimulus(0, 0, 2'b01, 8'h64, 8'h00, 0, 0, 8'h00);
    check_output("mid_pre_count", 32'(fifo_count), 32'd3);
    check_output("mid_pre_fbv", 32'(bus.fb_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_tx", 32'(bus.tx_bits), 32'h00);
    check_output("mid_rst_count", 32'(fifo_count), 32'd0);
    check_output("mid_rst_fbv", 32'(bus.fb_valid), 32'd0);
    check_output("mid_rst_ready", 32'(bus.src_ready), 32'd0);
    do_reset();

    // ---------------- ordered push from source 1 ----------------
    seq2[0] = 8'h21; seq2[1] = 8'h22; seq2[2] = 8'h23;
    exp_tx2[0] = 8'h22; exp_tx2[1] = 8'h23; exp_tx2[2] = 8'h00;
    apply_stimulus(0, 1, 2'b00, 8'h00, 8'h00, 0, 0, 8'h00);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 1, 2'b11, 8'h05, seq2[i], 0, 0, 8'h00);
      #1;
      check_output("src1_ready", 32'(bus.src_ready), 32'h2);
      step();
    end
    check_output("src1_head", 32'(bus.tx_bits), 32'h21);
    check_output("src1_count", 32'(fifo_count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 1, 2'b01, 8'h05, 8'h00, 1, 0, 8'h00);
      step();
      check_output("src1_drain_tx", 32'(bus.tx_bits), 32'(exp_tx2[i]));
    end
    check_output("src1_final_count", 32'(fifo_count), 32'd0);

    // ---------------- fill to full, overflow, one pop ----------------
    apply_stimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h00);
    step();
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, 0, 2'b01, 8'(8'h30 + i), 8'h00, 0, 0, 8'h00);
      #1;
      check_output("fill_ready", 32'(bus.src_ready), 32'h1);
      step();
    end
    check_output("full_count", 32'(fifo_count), 32'd8);
    apply_stimulus(0, 0, 2'b01, 8'h38, 8'h00, 0, 0, 8'h00);
    #1;
    check_output("full_ready", 32'(bus.src_ready), 32'h0);
    step();
    check_output("full_ovf", 32'(overflow), 32'd1);
    check_output("full_count_held", 32'(fifo_count), 32'd8);
    apply_stimulus(0, 0, 2'b01, 8'h38, 8'h00, 1, 0, 8'h00);
    #1;
    check_output("full_pop_ready", 32'(bus.src_ready), 32'h0);
    step();
    check_output("after_pop_count", 32'(fifo_count), 32'd7);
    check_output("after_pop_tx", 32'(bus.tx_bits), 32'h31);
    apply_stimulus(0, 0, 2'b01, 8'h38, 8'h00, 0, 0, 8'h00);
    #1;
    check_output("ninth_ready", 32'(bus.src_ready), 32'h1);
    step();
    check_output("ninth_count", 32'(fifo_count), 32'd8);
    check_output("ovf_sticky", 32'(overflow), 32'd1);

    // ---------------- push+pop, then flush with push+pop ----------------
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 0, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00);
      step();
      check_output("drain4_tx", 32'(bus.tx_bits), 32'(8'h32 + i));
    end
    check_output("drain4_count", 32'(fifo_count), 32'd4);
    apply_stimulus(0, 0, 2'b01, 8'h40, 8'h00, 1, 0, 8'h00);
    step();
    check_output("pushpop_count", 32'(fifo_count), 32'd4);
    check_output("pushpop_tx", 32'(bus.tx_bits), 32'h36);
    apply_stimulus(1, 0, 2'b01, 8'h41, 8'h00, 1, 0, 8'h00);
    #1;
    check_output("flush_ready", 32'(bus.src_ready), 32'h0);
    step();
    check_output("flush_count", 32'(fifo_count), 32'd0);
    check_output("flush_ovf", 32'(overflow), 32'd0);
    check_output("flush_tx", 32'(bus.tx_bits), 32'h00);

    // ---------------- back-to-back feedback ----------------
    apply_stimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 1, 8'h5A);
    step();
    check_output("fb1_valid", 32'(bus.fb_valid), 32'd1);
    check_output("fb1_bits", 32'(bus.fb_bits), 32'h5A);
    apply_stimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 1, 8'hC3);
    step();
    check_output("fb2_valid", 32'(bus.fb_valid), 32'd1);
    check_output("fb2_bits", 32'(bus.fb_bits), 32'hC3);
    apply_stimulus(0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 8'h00);
    step();
    check_output("fb3_valid", 32'(bus.fb_valid), 32'd0);
    check_output("fb3_bits", 32'(bus.fb_bits), 32'hC3);

    // ---------------- source switch with queued bytes ----------------
    apply_stimulus(0, 0, 2'b01, 8'h11, 8'h00, 0, 0, 8'h00);
    step();
    apply_stimulus(0, 0, 2'b01, 8'h12, 8'h00, 0, 0, 8'h00);
    step();
    check_output("sw_pre_count", 32'(fifo_count), 32'd2);
    apply_stimulus(0, 1, 2'b00, 8'h00, 8'h00, 0, 0, 8'h00);
`ifdef UART_CMD_BRIDGE_FLUSH_ON_SWITCH_EN
    #1;
    check_output("sw_ready", 32'(bus.src_ready), 32'h0);
    step();
    check_output("sw_count", 32'(fifo_count), 32'd0);
    check_output("sw_tx", 32'(bus.tx_bits), 32'h00);
`else
    step();
    check_output("sw_count", 32'(fifo_count), 32'd2);
    check_output("sw_tx0", 32'(bus.tx_bits), 32'h11);
    apply_stimulus(0, 1, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00);
    step();
    check_output("sw_tx1", 32'(bus.tx_bits), 32'h12);
    step();
    check_output("sw_tx2", 32'(bus.tx_bits), 32'h00);
    check_output("sw_count_end", 32'(fifo_count), 32'd0);
`endif

    // ---------------- randomized run against the model ----------------
    do_reset();
    mq.delete();
    movf  = 1'b0;
    mfb   = 8'h00;
    mfbv  = 1'b0;
    mprev = 1'b0;
    r_sel = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) r_sel = ~r_sel;
      r_v   = 2'($urandom);
      r_d0  = 8'($urandom);
      r_d1  = 8'($urandom);
      r_txr = ($urandom_range(0, 3) == 0);
      r_f   = ($urandom_range(0, 29) == 0);
      r_rxv = 1'($urandom);
      r_rxb = 8'($urandom);

      sw = 1'b0;
`ifdef UART_CMD_BRIDGE_FLUSH_ON_SWITCH_EN
      sw = (r_sel != mprev);
`endif
      clr     = r_f || sw;
      mfull   = (mq.size() == FIFO_DEPTH);
      exp_rdy = (clr || mfull) ? 2'b00 : (r_sel ? 2'b10 : 2'b01);

      apply_stimulus(r_f, r_sel, r_v, r_d0, r_d1, r_txr, r_rxv, r_rxb);
      #1;
      check_output("rnd_ready", 32'(bus.src_ready), 32'(exp_rdy));

      if (clr) begin
        mq.delete();
        movf = 1'b0;
      end else begin
        if (r_v[r_sel] && mfull) movf = 1'b1;
        if (r_txr && mq.size() > 0) void'(mq.pop_front());
        if (r_v[r_sel] && !mfull) mq.push_back(r_sel ? r_d1 : r_d0);
      end
      mfbv = r_rxv;
      if (r_rxv) mfb = r_rxb;
      mprev = r_sel;

      step();
      check_output("rnd_count", 32'(fifo_count), 32'(mq.size()));
      check_output("rnd_tx", 32'(bus.tx_bits), 32'((mq.size() > 0) ? mq[0] : 8'h00));
      check_output("rnd_ovf", 32'(overflow), 32'(movf));
      check_output("rnd_fbv", 32'(bus.fb_valid), 32'(mfbv));
      check_output("rnd_fb", 32'(bus.fb_bits), 32'(mfb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
